// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - shared AC-link constants and stereo sample type
package ac97_pkg;

    localparam int AC97_SLOT_W    = 20;
    localparam int AC97_FRAME_LEN = 256;

    typedef struct packed {
        logic [AC97_SLOT_W-1:0] left;
        logic [AC97_SLOT_W-1:0] right;
    } ac97_stereo_t;

endpackage

// File: rtl/ac97_pcm_fifo_if.sv
// rtl/ac97_pcm_fifo_if.sv - producer-side sample pair handshake
interface ac97_pcm_fifo_if;
    import ac97_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AC97_SLOT_W-1:0] in_left;
    logic [AC97_SLOT_W-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/ac97_sample_fifo.sv
// rtl/ac97_sample_fifo.sv - synchronous circular FIFO with wrap-bit pointers
module ac97_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 40
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ac97_pcm_fifo.sv
// rtl/ac97_pcm_fifo.sv - stereo PCM buffer feeding AC-link slots 3 and 4
module ac97_pcm_fifo
    import ac97_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int UCNT_W = 16
) (
    input  logic                    ac97_bitclk,
    input  logic                    ac97_rst,
    input  logic                    ac97_strobe,
    input  logic                    enable,
    input  logic                    flush,
    ac97_pcm_fifo_if.slave          in_if,
    output logic [AC97_SLOT_W-1:0]  ac97_out_slot3,
    output logic                    ac97_out_slot3_valid,
    output logic [AC97_SLOT_W-1:0]  ac97_out_slot4,
    output logic                    ac97_out_slot4_valid,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [UCNT_W-1:0]       underrun_count
);
    logic         full, empty, ready, push, pop;
    ac97_stereo_t wr_pair, head;

    logic [AC97_SLOT_W-1:0] slot3_q, slot3_d;
    logic [AC97_SLOT_W-1:0] slot4_q, slot4_d;
    logic                   valid_q, valid_d;
    logic [UCNT_W-1:0]      ucnt_q, ucnt_d;

    // Ready uses only registered fullness, so a same-cycle pop never frees a slot.
    assign ready          = !full && !ac97_rst && !flush;
    assign in_if.in_ready = ready;
    assign push           = in_if.in_valid && ready;
    assign pop            = ac97_strobe && enable && !empty && !flush;

    assign wr_pair.left  = in_if.in_left;
    assign wr_pair.right = in_if.in_right;

    ac97_sample_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(ac97_stereo_t))
    ) u_fifo (
        .clk_i   (ac97_bitclk),
        .rst_i   (ac97_rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_pair),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_comb begin
        slot3_d = slot3_q;
        slot4_d = slot4_q;
        valid_d = valid_q;
        ucnt_d  = ucnt_q;
        if (flush) begin
            slot3_d = '0;
            slot4_d = '0;
            valid_d = 1'b0;
        end else if (ac97_strobe) begin
            if (enable && !empty) begin
                slot3_d = head.left;
                slot4_d = head.right;
                valid_d = 1'b1;
            end else begin
                slot3_d = '0;
                slot4_d = '0;
                valid_d = 1'b0;
                if (enable && (ucnt_q != '1)) ucnt_d = ucnt_q + UCNT_W'(1);
            end
        end
    end

    always_ff @(posedge ac97_bitclk) begin
        if (ac97_rst) begin
            slot3_q <= '0;
            slot4_q <= '0;
            valid_q <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            slot3_q <= slot3_d;
            slot4_q <= slot4_d;
            valid_q <= valid_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign ac97_out_slot3       = slot3_q;
    assign ac97_out_slot4       = slot4_q;
    assign ac97_out_slot3_valid = valid_q;
    assign ac97_out_slot4_valid = valid_q;
    assign underrun_count       = ucnt_q;

endmodule

// File: tb/tb_ac97_pcm_fifo.sv
// tb/tb_ac97_pcm_fifo.sv - scoreboard bench for ac97_pcm_fifo
module tb_ac97_pcm_fifo;
    import ac97_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, strobe, enable, flush, strobe2;

    ac97_pcm_fifo_if pif ();
    ac97_pcm_fifo_if pif2 ();

    logic [19:0] s3, s4, t3, t4;
    logic        v3, v4, w3, w4;
    logic [4:0]  level;
    logic [2:0]  level2;
    logic [15:0] ucnt;
    logic [3:0]  ucnt2;

    ac97_pcm_fifo #(.DEPTH(DEPTH), .UCNT_W(16)) dut (
        .ac97_bitclk          (clk),
        .ac97_rst             (rst),
        .ac97_strobe          (strobe),
        .enable               (enable),
        .flush                (flush),
        .in_if                (pif.slave),
        .ac97_out_slot3       (s3),
        .ac97_out_slot3_valid (v3),
        .ac97_out_slot4       (s4),
        .ac97_out_slot4_valid (v4),
        .fifo_level           (level),
        .underrun_count       (ucnt)
    );

    ac97_pcm_fifo #(.DEPTH(4), .UCNT_W(4)) dut2 (
        .ac97_bitclk          (clk),
        .ac97_rst             (rst),
        .ac97_strobe          (strobe2),
        .enable               (1'b1),
        .flush                (1'b0),
        .in_if                (pif2.slave),
        .ac97_out_slot3       (t3),
        .ac97_out_slot3_valid (w3),
        .ac97_out_slot4       (t4),
        .ac97_out_slot4_valid (w4),
        .fifo_level           (level2),
        .underrun_count       (ucnt2)
    );

    int checks = 0;
    int errors = 0;

    ac97_stereo_t q[$];
    logic [19:0]  exp_s3 = '0, exp_s4 = '0;
    logic         exp_v = 1'b0;
    logic [15:0]  exp_ucnt = '0;
    logic [3:0]   exp_ucnt2 = '0;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs in force, then compare.
    task automatic step();
        ac97_stereo_t pair, head;
        bit           acc;
        acc        = pif.in_valid && !rst && !flush && (q.size() < DEPTH);
        pair.left  = pif.in_left;
        pair.right = pif.in_right;
        if (rst) begin
            q.delete();
            exp_s3 = '0; exp_s4 = '0; exp_v = 1'b0; exp_ucnt = '0;
        end else if (flush) begin
            q.delete();
            exp_s3 = '0; exp_s4 = '0; exp_v = 1'b0;
        end else begin
            if (strobe) begin
                if (enable && q.size() > 0) begin
                    head   = q.pop_front();
                    exp_s3 = head.left;
                    exp_s4 = head.right;
                    exp_v  = 1'b1;
                end else begin
                    exp_s3 = '0; exp_s4 = '0; exp_v = 1'b0;
                    if (enable && exp_ucnt != 16'hFFFF) exp_ucnt++;
                end
            end
            if (acc) q.push_back(pair);
        end
        @(posedge clk);
        #1;
        check("slot3", s3, exp_s3);
        check("slot4", s4, exp_s4);
        check("slot3_valid", v3, exp_v);
        check("slot4_valid", v4, exp_v);
        check("fifo_level", level, 40'(q.size()));
        check("underrun_count", ucnt, exp_ucnt);
        check("in_ready", pif.in_ready, !rst && !flush && (q.size() < DEPTH));
    endtask

    task automatic push_pair(input logic [19:0] l, input logic [19:0] r);
        pif.in_valid = 1'b1;
        pif.in_left  = l;
        pif.in_right = r;
        step();
        pif.in_valid = 1'b0;
    endtask

    task automatic pulse_strobe();
        strobe = 1'b1;
        step();
        strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; enable = 1'b1; flush = 1'b0; strobe2 = 1'b0;
        pif.in_valid = 1'b0; pif.in_left = '0; pif.in_right = '0;
        pif2.in_valid = 1'b0; pif2.in_left = '0; pif2.in_right = '0;

        step();
        step();
        rst = 1'b0;
        #1;
        check("ready_after_reset", pif.in_ready, 1'b1);

        // Three pairs, four full-length frames; the fourth starves.
        for (int i = 0; i < 3; i++) push_pair(20'(i + 1), 20'hFFFFF - 20'(i));
        for (int f = 0; f < 4; f++) begin
            pulse_strobe();
            repeat (AC97_FRAME_LEN - 1) step();
        end
        check("first_underrun", ucnt, 16'd1);

        // Fill to capacity; a strobe with in_valid high while full must not accept.
        for (int i = 0; i < DEPTH; i++) push_pair(20'($urandom), 20'($urandom));
        check("level_full", level, 40'd16);
        check("ready_full", pif.in_ready, 1'b0);
        pif.in_valid = 1'b1; pif.in_left = 20'hAAAAA; pif.in_right = 20'h55555;
        strobe = 1'b1;
        step();
        strobe = 1'b0; pif.in_valid = 1'b0;
        check("level_after_full_pop", level, 40'd15);
        check("ready_after_full_pop", pif.in_ready, 1'b1);
        for (int i = 0; i < 15; i++) begin
            pulse_strobe();
            step();
        end
        pulse_strobe();
        check("drain_underrun", ucnt, 16'd2);

        // Push coincident with strobe on empty FIFO: no bypass.
        pif.in_valid = 1'b1; pif.in_left = 20'h12345; pif.in_right = 20'hFEDCB;
        strobe = 1'b1;
        step();
        strobe = 1'b0; pif.in_valid = 1'b0;
        check("coincident_valid", v3, 1'b0);
        check("coincident_count", ucnt, 16'd3);
        step();
        pulse_strobe();
        check("coincident_next_left", s3, 20'h12345);
        check("coincident_next_right", s4, 20'hFEDCB);

        // Disabled playback: no pops, no counting.
        for (int i = 0; i < 4; i++) push_pair(20'h10 + 20'(i), 20'h20 + 20'(i));
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse_strobe();
            step();
        end
        check("disabled_level", level, 40'd4);
        check("disabled_count", ucnt, 16'd3);
        check("disabled_valid", v3, 1'b0);
        enable = 1'b1;

        // Flush with 8 stored while slots are valid.
        for (int i = 0; i < 5; i++) push_pair(20'($urandom), 20'($urandom));
        pulse_strobe();
        check("pre_flush_level", level, 40'd8);
        flush = 1'b1;
        pif.in_valid = 1'b1;
        strobe = 1'b1;
        step();
        flush = 1'b0; pif.in_valid = 1'b0; strobe = 1'b0;
        check("flush_level", level, 40'd0);
        check("flush_slot3", s3, 20'd0);
        check("flush_count_kept", ucnt, 16'd3);
        step();

        // Narrow counter saturates at all-ones.
        for (int i = 0; i < 20; i++) begin
            strobe2 = 1'b1;
            @(posedge clk);
            #1;
            strobe2 = 1'b0;
            if (exp_ucnt2 != 4'hF) exp_ucnt2++;
            check("sat_count", ucnt2, exp_ucnt2);
            check("sat_valid", w3, 1'b0);
        end
        check("sat_final", ucnt2, 4'hF);

        // Reset mid-frame with 5 entries stored.
        for (int i = 0; i < 6; i++) push_pair(20'h300 + 20'(i), 20'h400 + 20'(i));
        pulse_strobe();
        repeat (10) step();
        check("pre_reset_level", level, 40'd5);
        rst = 1'b1;
        step();
        check("reset_valid", v4, 1'b0);
        check("reset_level", level, 40'd0);
        check("reset_count", ucnt, 16'd0);
        rst = 1'b0;
        #1;
        check("ready_after_midreset", pif.in_ready, 1'b1);
        step();
        pulse_strobe();
        check("post_reset_underrun", ucnt, 16'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac97_pcm_fifo.md
# ac97_pcm_fifo

Stereo PCM sample buffer that feeds the playback slots of the AC-link serializer. A sample producer (wave generator, DMA, or mixer) pushes 20-bit left/right pairs with a valid/ready handshake. On each frame strobe, one pair is popped and held on slot 3 (left) and slot 4 (right) for the whole frame. Underruns are flagged in the TAG valid bits and counted. The block runs entirely in the `ac97_bitclk` domain, directly upstream of the link serializer.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries (sample pairs); power of two, ≥2
- `UCNT_W`, 16: underrun counter width

Ports:
- `ac97_bitclk`  in  1  sole clock; all logic on its rising edge
- `ac97_rst`  in  1  reset, synchronous, active-high
- `ac97_strobe`  in  1  one-cycle pulse per 256-bit frame, from the link
- `enable`  in  1  playback enable
- `flush`  in  1  synchronous FIFO clear
- `in_valid`  in  1  producer has a pair
- `in_ready`  out  1  FIFO can accept a pair
- `in_left`  in  20  left sample, two's complement
- `in_right`  in  20  right sample, two's complement
- `ac97_out_slot3`  out  20  left PCM to the link
- `ac97_out_slot3_valid`  out  1  slot 3 TAG valid
- `ac97_out_slot4`  out  20  right PCM to the link
- `ac97_out_slot4_valid`  out  1  slot 4 TAG valid
- `fifo_level`  out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH
- `underrun_count`  out  UCNT_W  saturating count of starved frames

## Operation
- Storage is a circular buffer of DEPTH × 40-bit entries, `{left, right}`.
  - Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = indices equal and wrap bits differ.
- Push occurs when `in_valid && in_ready`. `in_ready = !full && !ac97_rst && !flush`, computed from registered state only. A pop in the same cycle does not open space for a push.
- Pop decision, made only on cycles with `ac97_strobe` high:
  - `enable && !empty`: load the head into the slot3/slot4 registers, set both valids to 1, and advance the read pointer.
  - `enable && empty` (underrun): zero both slot registers, clear both valids, and increment `underrun_count`. The counter saturates at all-ones.
  - `!enable`: zero the slots and clear the valids. No pop, no count.
- Slot outputs and valids change only on strobe cycles (and on reset/flush). They are otherwise held, so the serializer sees stable data for the full frame.
- Push and strobe in the same cycle:
  - When not full, the push is always accepted.
  - When the FIFO is empty, there is no bypass: the frame underruns and the pushed pair is stored for the next frame.
- `flush`: pointers go to 0 and `fifo_level` to 0. Slot outputs are zeroed and their valids cleared. `underrun_count` is retained. Flush has priority over push, pop and strobe in that cycle.
- `fifo_level` = write pointer − read pointer, modulo 2^(ptr width).

## Timing
- Reset values: slots 0, valids 0, `fifo_level` 0, `underrun_count` 0, `in_ready` 0 while `ac97_rst` is high. `in_ready` is 1 on the first cycle after reset.
- Reset has priority over every other input. Asserting it mid-frame discards contents and clears the outputs at the next edge.
- Data latency: a pair pushed at edge N is eligible for the first strobe at edge > N. Outputs update at the edge ending the strobe cycle, i.e. stable from link bit 1, well ahead of slot 3 at bit 56.
- `fifo_level` and `in_ready` update one edge after the push or pop.

## Structure
- Shared `ac97_pkg` holds:
  - `AC97_SLOT_W` = 20
  - the typedef `ac97_stereo_t {logic [19:0] left, right;}`
  - the frame-length constant 256
- Natural sub-module: `ac97_sample_fifo`, a generic synchronous FIFO with push/pop/flush, full/empty and level. The top adds strobe-gated pop, output holding registers and the underrun counter.

## Test plan
- Reset, then push 3 pairs (L=0x00001/R=0xFFFFF, 0x00002/0xFFFFE, 0x00003/0xFFFFD) and pulse strobe every 256 cycles → slots show those pairs in order, each held 256 cycles with valids 1. The fourth strobe gives zeros, valids 0 and `underrun_count`=1.
- Push 16 pairs with no strobe → `fifo_level`=16 and `in_ready`=0. Strobe and in_valid in the same cycle → no push accepted that cycle; `in_ready`=1 on the next cycle.
- Empty FIFO, push coincident with strobe → underrun counted, valids 0; the pair appears at the next strobe.
- Hold `enable`=0 across 5 strobes with 4 entries stored → outputs 0/invalid, `fifo_level` stays 4, `underrun_count` unchanged.
- `flush` with 8 entries while slots are valid → `fifo_level`=0, outputs zero, counter kept. Preload `underrun_count` near saturation with `UCNT_W`=4 → it sticks at 15.
- Assert `ac97_rst` mid-frame with 5 entries → all outputs at reset values on the next edge; the first subsequent strobe underruns.
